score_renderer: RTL
===================

Name: score_renderer

Overview:
- Reader side of the glyph sprite ROM (12 glyphs of 20x25, 5-bit palette index; glyph order 0-9, 'L'=10, 'S'=11; one-cycle registered read; two read ports).
- Converts the binary score to BCD with a sequential double-dabble once per frame.
- Maps each DrawX/DrawY pixel to ROM addresses and returns an on-flag and palette index to the colour mapper.
- Draws two rows: a score row on ROM port 0 and a lives row on ROM port 1.

Parameters:
- GLYPH_W, 20, glyph width in pixels.
- GLYPH_H, 25, glyph height in pixels.
- DIGITS, 4, score digit count (max displayed 9999).
- X0, 16, left edge of both rows.
- Y0, 8, top of the score row.
- ROW_GAP, 4, vertical pixels between the score row and the lives row.

Ports:
- Clk  in  1  pixel-domain clock.
- Reset_n  in  1  synchronous reset, active-low.
- frame_start  in  1  one-cycle pulse at the start of vertical blank.
- score  in  14  binary score.
- lives  in  4  lives count.
- DrawX  in  10  current pixel x.
- DrawY  in  10  current pixel y.
- read_address0  out  15  ROM port 0 address (score row).
- read_address1  out  15  ROM port 1 address (lives row).
- data_Out0  in  5  ROM port 0 data; valid one cycle after its address.
- data_Out1  in  5  ROM port 1 data.
- pix_on  out  1  high when a glyph covers the pixel and the palette index is non-zero.
- pix_idx  out  5  palette index; 0 when pix_on is low.
- bcd_busy  out  1  conversion in progress.

Behaviour:
- Reset (Reset_n low at a Clk edge):
  - read_address0/1 = 0, pix_on = 0, pix_idx = 0, bcd_busy = 0.
  - Displayed digit registers = 0,0,0,0; displayed lives = 0.
  - FSM returns to IDLE; an in-flight conversion is discarded and display registers keep their reset value.
- Conversion FSM, states IDLE, SHIFT, DONE:
  - IDLE: on frame_start, latch min(score, 9999) and min(lives, 9); clear the 16-bit BCD accumulator; go to SHIFT; bcd_busy = 1.
  - SHIFT: 14 iterations, one per cycle. Each iteration adds 3 to every nibble >= 5, then shifts left, bringing in the binary MSB.
  - DONE: copy the accumulator and the latched lives into the display registers in the same cycle; bcd_busy = 0; return to IDLE.
  - Timing: busy for 15 cycles; display updates on the 16th edge after frame_start.
  - frame_start while busy is ignored.
  - The display registers never change mid-conversion, so there is no tearing.
- Layout:
  - Score row y in [Y0, Y0+25).
    - Slot 0 = 'S' at x in [X0, X0+20).
    - Slots 1..4 = digits, most significant first, at X0+20*k.
  - Lives row y in [Y0+25+ROW_GAP, +25).
    - Slot 0 = 'L'.
    - Slot 1 = the lives digit.
  - Leading zero blanking: score digits left of the first non-zero digit are blank (no ROM hit). The last digit is always drawn, so 0 displays as "S   0".
- Address:
  - Address = glyph*500 + (DrawY-rowtop)*20 + (DrawX-slotleft), 15 bits.
  - Maximum address is 5999; the arithmetic never exceeds 15 bits.
  - Outside any slot, the address is don't-care but driven to 0.
- Pipeline and latency:
  - Cycle n: DrawX/DrawY presented.
  - Edge n+1: read_address0/1 and the per-row hit flags are registered.
  - Edge n+2: ROM data returns.
  - pix_on/pix_idx are registered at edge n+3. Fixed latency is 3 cycles; the colour mapper delays DrawX/Y to match.
  - Score-row hit selects data_Out0, lives-row hit selects data_Out1. The rows never overlap.
  - Palette index 0 is transparent: pix_on = 0, pix_idx = 0.
- Boundaries:
  - DrawX/DrawY exactly at X0 or Y0 is inside the slot.
  - X0+20*5 is outside the score row; X0+40 is outside the lives row.
  - Score 16383 displays 9999. Lives 15 displays 9.

Test Plan:
- Reset_n low 2 cycles mid-conversion (score=1234), release -> bcd_busy=0, digits 0000; no update until the next frame_start.
- score=1234, frame_start pulse -> bcd_busy high exactly 15 cycles; display digits 1,2,3,4 on edge 16. Pixel (X0+20,Y0) -> read_address0 = 1*500 = 500 one cycle later.
- score=7, lives=3 -> pixels in slots 1-3 produce pix_on=0 with no ROM-driven index. Pixel (X0+85,Y0+10) -> address 7*500+10*20+5 = 3705. Lives row pixel (X0+20,Y0+29) -> read_address1 = 1500.
- score=16383, lives=15 -> digits 9,9,9,9; lives 9. frame_start repeated during busy -> ignored, busy still ends after 15 cycles.
- ROM model returning 0 then 0x1A at a hit pixel -> pix_on=0/pix_idx=0, then pix_on=1/pix_idx=0x1A, each exactly 3 cycles after its DrawX/DrawY.
- Sweep DrawX = X0-1, X0, X0+99, X0+100 on row Y0 -> hit only at X0 ('S', address 5500) and X0+99 (last digit, column 19).

Source files
------------

// File: rtl/score_renderer.sv
// Score/lives glyph renderer: converts the score to BCD once per frame and turns each
// DrawX/DrawY into glyph ROM addresses, returning a palette index three cycles later.
module score_renderer #(
  parameter int unsigned GLYPH_W = 20,
  parameter int unsigned GLYPH_H = 25,
  parameter int unsigned DIGITS  = 4,
  parameter int unsigned X0      = 16,
  parameter int unsigned Y0      = 8,
  parameter int unsigned ROW_GAP = 4
) (
  input  logic        Clk,
  input  logic        Reset_n,
  input  logic        frame_start,
  input  logic [13:0] score,
  input  logic [3:0]  lives,
  input  logic [9:0]  DrawX,
  input  logic [9:0]  DrawY,
  output logic [14:0] read_address0,
  output logic [14:0] read_address1,
  input  logic [4:0]  data_Out0,
  input  logic [4:0]  data_Out1,
  output logic        pix_on,
  output logic [4:0]  pix_idx,
  output logic        bcd_busy
);

  localparam logic [9:0]  XL        = 10'(X0);
  localparam logic [9:0]  YScore    = 10'(Y0);
  localparam logic [9:0]  YLives    = 10'(Y0 + GLYPH_H + ROW_GAP);
  localparam logic [9:0]  GH        = 10'(GLYPH_H);
  localparam logic [14:0] GlyphSize = 15'(GLYPH_W * GLYPH_H);
  localparam logic [14:0] RowPitch  = 15'(GLYPH_W);
  localparam logic [3:0]  GlyphL    = 4'd10;
  localparam logic [3:0]  GlyphS    = 4'd11;

  typedef enum logic [1:0] {StIdle, StShift, StDone} state_t;

  state_t      state;
  logic [13:0] bin_q;
  logic [15:0] acc_q;
  logic [3:0]  lives_lat_q;
  logic [3:0]  iter_q;
  logic [15:0] disp_q;
  logic [3:0]  disp_lives_q;
  logic [15:0] acc_adj;

  // Double-dabble correction: every nibble >= 5 gets +3 before the shift.
  always_comb begin
    acc_adj = acc_q;
    for (int i = 0; i < 4; i++) begin
      if (acc_q[4*i +: 4] >= 4'd5) acc_adj[4*i +: 4] = acc_q[4*i +: 4] + 4'd3;
    end
  end

  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      state        <= StIdle;
      bin_q        <= '0;
      acc_q        <= '0;
      lives_lat_q  <= '0;
      iter_q       <= '0;
      disp_q       <= '0;
      disp_lives_q <= '0;
      bcd_busy     <= 1'b0;
    end else begin
      unique case (state)
        StIdle: begin
          if (frame_start) begin
            bin_q       <= (score > 14'd9999) ? 14'd9999 : score;
            lives_lat_q <= (lives > 4'd9) ? 4'd9 : lives;
            acc_q       <= '0;
            iter_q      <= '0;
            bcd_busy    <= 1'b1;
            state       <= StShift;
          end
        end
        StShift: begin
          acc_q  <= {acc_adj[14:0], bin_q[13]};
          bin_q  <= {bin_q[12:0], 1'b0};
          iter_q <= iter_q + 4'd1;
          if (iter_q == 4'd13) state <= StDone;
        end
        StDone: begin
          disp_q       <= acc_q;
          disp_lives_q <= lives_lat_q;
          bcd_busy     <= 1'b0;
          state        <= StIdle;
        end
        default: state <= StIdle;
      endcase
    end
  end

  logic        in_y0, in_y1, hit0, hit1, seen, draw;
  logic [3:0]  glyph0, glyph1, dig;
  logic [9:0]  col0, col1, lo, hi;
  logic [14:0] addr0, addr1;

  always_comb begin
    in_y0  = (DrawY >= YScore) && (DrawY < YScore + GH);
    in_y1  = (DrawY >= YLives) && (DrawY < YLives + GH);
    hit0   = 1'b0;
    hit1   = 1'b0;
    glyph0 = '0;
    glyph1 = '0;
    col0   = '0;
    col1   = '0;
    seen   = 1'b0;
    draw   = 1'b0;
    dig    = '0;
    lo     = '0;
    hi     = '0;
    for (int k = 0; k <= int'(DIGITS); k++) begin
      lo = XL + 10'(k * GLYPH_W);
      hi = lo + 10'(GLYPH_W);
      if (k == 0) begin
        dig  = GlyphS;
        draw = 1'b1;
      end else begin
        // Leading zeros blank; the units digit is always drawn.
        dig  = disp_q[4*(int'(DIGITS)-k) +: 4];
        seen = seen | (dig != 4'd0);
        draw = seen | (k == int'(DIGITS));
      end
      if (in_y0 && draw && DrawX >= lo && DrawX < hi) begin
        hit0   = 1'b1;
        glyph0 = dig;
        col0   = DrawX - lo;
      end
      if (k < 2 && in_y1 && DrawX >= lo && DrawX < hi) begin
        hit1   = 1'b1;
        glyph1 = (k == 0) ? GlyphL : disp_lives_q;
        col1   = DrawX - lo;
      end
    end
    addr0 = {11'd0, glyph0} * GlyphSize + {5'd0, DrawY - YScore} * RowPitch + {5'd0, col0};
    addr1 = {11'd0, glyph1} * GlyphSize + {5'd0, DrawY - YLives} * RowPitch + {5'd0, col1};
  end

  logic       hit0_q, hit1_q, hit0_qq, hit1_qq;
  logic [4:0] rom_pix;

  always_comb begin
    rom_pix = '0;
    if (hit0_qq)      rom_pix = data_Out0;
    else if (hit1_qq) rom_pix = data_Out1;
  end

  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      read_address0 <= '0;
      read_address1 <= '0;
      hit0_q        <= 1'b0;
      hit1_q        <= 1'b0;
      hit0_qq       <= 1'b0;
      hit1_qq       <= 1'b0;
      pix_on        <= 1'b0;
      pix_idx       <= '0;
    end else begin
      read_address0 <= hit0 ? addr0 : 15'd0;
      read_address1 <= hit1 ? addr1 : 15'd0;
      hit0_q        <= hit0;
      hit1_q        <= hit1;
      hit0_qq       <= hit0_q;
      hit1_qq       <= hit1_q;
      pix_on        <= (rom_pix != 5'd0);
      pix_idx       <= rom_pix;
    end
  end

endmodule
